// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter between the core fetch port and the SPI loader port.
// One grant per cycle, CPU-first with a starvation guard for the loader.
module imem_arbiter #(
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_err,
  output logic                  dbg_rvalid,
  output logic [31:0]           dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CPU,
    SRC_DBG,
    SRC_NOP
  } rd_src_t;

  rd_src_t        rd_src;
  rd_src_t        rd_src_next;
  logic [WCW-1:0] wait_cnt;
  logic [31:0]    cpu_rdata_q;
  logic [31:0]    dbg_rdata_q;

  logic cpu_oor;
  logic dbg_oor;
  logic dbg_bad;
  logic dbg_wins;
  logic cpu_mem;
  logic dbg_mem;

  logic [DEPTH_LOG2-1:0] cpu_word;
  logic [DEPTH_LOG2-1:0] dbg_word;

  // Fetches are word-aligned by construction, so the low byte-offset bits carry no meaning.
  logic unused_cpu_offset;
  assign unused_cpu_offset = ^cpu_addr[1:0];

  assign cpu_word = cpu_addr[DEPTH_LOG2+1:2];
  assign dbg_word = dbg_addr[DEPTH_LOG2+1:2];
  assign cpu_oor  = |cpu_addr[31:DEPTH_LOG2+2];
  assign dbg_oor  = |dbg_addr[31:DEPTH_LOG2+2];
  assign dbg_bad  = dbg_oor || (dbg_addr[1:0] != 2'b00);

  always_comb begin
    dbg_wins    = 1'b0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    dbg_err     = 1'b0;
    cpu_mem     = 1'b0;
    dbg_mem     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rd_src_next = SRC_NONE;

    if (!rst) begin
      // The loader only takes the slot when the core is idle or it has waited long enough.
      dbg_wins = dbg_req && (!cpu_req || (wait_cnt == WAIT_LIMIT));
      cpu_gnt  = cpu_req && !dbg_wins;
      dbg_gnt  = dbg_wins;
      dbg_err  = dbg_gnt && dbg_bad;
      cpu_mem  = cpu_gnt && !cpu_oor;
      dbg_mem  = dbg_gnt && !dbg_bad;
      mem_en   = cpu_mem || dbg_mem;
      mem_we   = dbg_mem && dbg_we;

      if (dbg_mem) begin
        mem_addr = dbg_word;
        if (dbg_we)
          mem_wdata = dbg_wdata;
      end else if (cpu_mem) begin
        mem_addr = cpu_word;
      end

      if (cpu_gnt)
        rd_src_next = cpu_oor ? SRC_NOP : SRC_CPU;
      else if (dbg_mem && !dbg_we)
        rd_src_next = SRC_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_src   <= SRC_NONE;
      wait_cnt <= '0;
    end else begin
      rd_src <= rd_src_next;
      if (!dbg_req || dbg_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIMIT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read data is taken straight from the SRAM in the response cycle; the hold
  // registers keep the last value visible once the response has passed.
  always_comb begin
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    cpu_rdata  = cpu_rdata_q;
    dbg_rdata  = dbg_rdata_q;
    if (rst) begin
      cpu_rdata = '0;
      dbg_rdata = '0;
    end else begin
      case (rd_src)
        SRC_CPU: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
        end
        SRC_NOP: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = NOP_INSN;
        end
        SRC_DBG: begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 1-cycle-latency SRAM model.
module tb_imem_arbiter;

  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [31:0]   dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_err;
  logic          dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [DL-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] memArray [0:(1<<DL)-1];

  int checkCount = 0;
  int errorCount = 0;

  imem_arbiter #(.DEPTH_LOG2(DL), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_err(dbg_err), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: reads land on mem_rdata one cycle after the command.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        memArray[mem_addr] <= mem_wdata;
      else
        mem_rdata <= memArray[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cReq, input logic [31:0] cAddr,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata);
    rst       = r;
    cpu_req   = cReq;
    cpu_addr  = cAddr;
    dbg_req   = dReq;
    dbg_we    = dWe;
    dbg_addr  = dAddr;
    dbg_wdata = dWdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<DL); i++)
      memArray[i] = 32'hA5A5_0000 ^ i;
    memArray[4] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;

    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
      checkOutput("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
      checkOutput("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      checkOutput("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
      nextCycle();
    end
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);

    // First cycle out of reset: both requesting, CPU wins and fetches 0x10.
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("first_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    checkOutput("first_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    checkOutput("fetch_mem_en", {31'b0, mem_en}, 32'd1);
    checkOutput("fetch_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("fetch_mem_addr", {22'b0, mem_addr}, 32'd4);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    checkOutput("fetch_rdata", cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("fetch_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    nextCycle();

    // Starvation: CPU fetches back to back, loader write wins on its 5th cycle.
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        checkOutput("starve_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        checkOutput("starve_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
        checkOutput("starve_mem_addr", {22'b0, mem_addr}, 32'd8);
      end else begin
        checkOutput("override_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        checkOutput("override_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
        checkOutput("override_dbg_err", {31'b0, dbg_err}, 32'd0);
        checkOutput("override_mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("override_mem_addr", {22'b0, mem_addr}, 32'd16);
        checkOutput("override_mem_wdata", mem_wdata, 32'h1234_5678);
      end
      if (k > 1) begin
        checkOutput("b2b_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        checkOutput("b2b_cpu_rdata", cpu_rdata, 32'hA5A5_0008);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("after_write_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    checkOutput("after_write_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    nextCycle();

    // Loader read-back of the word just written.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("rb_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    checkOutput("rb_dbg_err", {31'b0, dbg_err}, 32'd0);
    checkOutput("rb_mem_en", {31'b0, mem_en}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rb_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    checkOutput("rb_dbg_rdata", dbg_rdata, 32'h1234_5678);
    checkOutput("rb_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    nextCycle();

    // Malformed loader reads: misaligned, then out of range.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, (k == 0) ? 32'h42 : 32'h0001_0000, 32'h0);
      @(negedge clk);
      checkOutput("bad_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
      checkOutput("bad_dbg_err", {31'b0, dbg_err}, 32'd1);
      checkOutput("bad_mem_en", {31'b0, mem_en}, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("bad_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
      nextCycle();
    end

    // Rejected loader access while the CPU also requests: CPU keeps the slot.
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h42, 32'h0);
    @(negedge clk);
    checkOutput("bad_vs_cpu_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    checkOutput("bad_vs_cpu_dbg_err", {31'b0, dbg_err}, 32'd0);
    nextCycle();

    // CPU fetch out of range returns a NOP without touching memory.
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("oor_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    checkOutput("oor_mem_en", {31'b0, mem_en}, 32'd0);
    checkOutput("oor_mem_addr", {22'b0, mem_addr}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("oor_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    checkOutput("oor_cpu_rdata", cpu_rdata, 32'h0000_0013);
    nextCycle();

    // Loader read granted, then reset on the following edge.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("pre_rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("midrst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    checkOutput("midrst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    checkOutput("midrst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("postrst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    checkOutput("postrst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    checkOutput("postrst_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
